decode_execute_pipe: RTL and testbench
======================================

Name: decode_execute_pipe

Overview:
- Parametrised Decode->Execute pipeline register with valid/ready handshake, a 2-entry skid buffer, synchronous flush and a saturating stall counter.
- Sits between the Decode stage and the ALU/Execute stage.
- Adds backpressure, bubble-on-flush and configurable widths, which a plain always-load stage register does not provide.

Parameters:
DATA_W, 32, width of val1, val2 and store data
REG_W, 4, width of register indices (dest, src1, src2)
CMD_W, 4, width of EXE_CMD
CNT_W, 16, width of stall_cycles counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
flush  in  1  synchronous kill of all held entries (branch taken / exception)
in_valid  in  1  Decode presents a valid bundle
in_ready  out  1  stage can accept a bundle this cycle
dest_in  in  REG_W  destination register
mem_r_en_in, mem_w_en_in, wb_en_in, br_taken_in  in  1 each  control enables
exe_cmd_in  in  CMD_W  ALU command
src1_in, src2_in  in  REG_W  source register indices, for forwarding
val1_in, val2_in  in  DATA_W  operand values
st_val_in  in  DATA_W  store data (reg2)
out_valid  out  1  Execute bundle valid
out_ready  in  1  Execute accepts bundle
dest_out, exe_cmd_out, src1_out, src2_out, val1_out, val2_out, st_val_out  out  per field  registered payload
mem_r_en_out, mem_w_en_out, wb_en_out, br_taken_out  out  1 each  control enables, gated by out_valid
stall_cycles  out  CNT_W  count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (rst=0, async): state EMPTY; all payload registers 0; out_valid 0; stall_cycles 0; in_ready forced 0 while rst=0.
- in_ready = (state != SKID) when out of reset. It depends on state only and has no combinational path from out_ready.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- out_valid = (state != EMPTY). Outputs always show the MAIN entry.
- States and transitions (flush=0):
  - EMPTY: in_fire -> MAIN<=in, FULL.
  - FULL: in_fire & out_fire -> MAIN<=in, stay FULL. in_fire & !out_ready -> SKID<=in, go SKID. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - SKID: out_fire -> MAIN<=SKID entry, FULL. Otherwise hold. in_valid is ignored because in_ready=0.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty; full throughput of 1 bundle/cycle while out_ready=1.
- flush=1 (highest priority after reset): next state EMPTY and stored control enables cleared. A bundle offered in the same cycle is dropped, even if in_valid=1. Data fields may retain stale values.
- Control outputs are AND-ed with out_valid, so a bubble never issues mem/wb/branch.
- stall_cycles increments each cycle with out_valid & !out_ready and saturates at 2^CNT_W-1. It is cleared only by reset, not by flush.
- No width conversion: all fields pass through unmodified at their parameter widths.
- Reset mid-transfer: all entries are discarded and in_ready returns 1 on the first clock after rst deasserts.

Decomposition:
- Package de_pipe_pkg:
  - de_payload_t packed struct (all payload fields, parameter-sized via package localparams mirroring the defaults).
  - enum de_state_t {EMPTY, FULL, SKID}.
  - Helper function to zero control enables.
- One generic sub-module, pipe_skid_buffer, parametrised on payload width. It holds the FSM and both entry registers and has a flush input.
- decode_execute_pipe packs/unpacks de_payload_t, gates control outputs and implements stall_cycles.

Test Plan:
- Reset then stream: out_ready=1; push 3 bundles dest=1,2,3 on consecutive cycles -> out_valid high from cycle 1; dest_out 1,2,3 on consecutive cycles; in_ready stays 1.
- Backpressure skid: out_ready=0; push A (val1=0xAAAA_0001), then B (0xBBBB_0002) -> in_ready drops to 0 after B, state SKID. Raise out_ready -> A then B emitted in order, no loss or duplication. stall_cycles equals the number of stalled cycles.
- Flush in SKID with in_valid=1 and wb_en_in=1 -> next cycle out_valid=0 and wb_en_out=0; in_ready=1; offered bundle not emitted.
- Saturation: CNT_W=4, hold out_valid with out_ready=0 for 20 cycles -> stall_cycles stops at 15.
- Async reset mid-stream: drop rst between clock edges while FULL -> out_valid, all control outputs and stall_cycles read 0 immediately, without waiting for a clock edge; in_ready=0 until rst=1.
- Param sweep: DATA_W=64, REG_W=5 -> val2_in 0xDEAD_BEEF_0123_4567 and src2_in 31 pass through intact.

Source files
------------

// File: rtl/de_pipe_pkg.sv
// de_pipe_pkg: shared types and helpers for the decode->execute pipeline register
package de_pipe_pkg;
  localparam int DE_DATA_W = 32;
  localparam int DE_REG_W = 4;
  localparam int DE_CMD_W = 4;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} de_state_t;
  typedef struct packed {
    logic mem_r_en;
    logic mem_w_en;
    logic wb_en;
    logic br_taken;
  } de_ctrl_t;
  localparam int CTRL_W = $bits(de_ctrl_t);
  typedef struct packed {
    logic [DE_REG_W-1:0] dest;
    logic [DE_CMD_W-1:0] exe_cmd;
    logic [DE_REG_W-1:0] src1;
    logic [DE_REG_W-1:0] src2;
    logic [DE_DATA_W-1:0] val1;
    logic [DE_DATA_W-1:0] val2;
    logic [DE_DATA_W-1:0] st_val;
    de_ctrl_t ctrl;
  } de_payload_t;
  function automatic de_ctrl_t ctrl_keep(de_ctrl_t c, logic keep);
    return keep ? c : '0;
  endfunction
endpackage

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: valid/ready register stage with a second skid entry and flush
module pipe_skid_buffer import de_pipe_pkg::*; #(
  parameter int W = 8,
  parameter logic [W-1:0] KEEP_MASK = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  de_state_t state;
  logic [W-1:0] main_q, skid_q;
  logic in_fire;
  assign in_ready = rst & (state != SKID);
  assign out_valid = state != EMPTY;
  assign out_data = main_q;
  assign in_fire = in_valid & in_ready;
  // entry FSM; flush empties the stage and clears the bits outside KEEP_MASK
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
      main_q <= main_q & KEEP_MASK;
      skid_q <= skid_q & KEEP_MASK;
    end else
      case (state)
        EMPTY: if (in_fire) begin
          main_q <= in_data;
          state <= FULL;
        end
        FULL: if (in_fire && out_ready) main_q <= in_data;
        else if (in_fire) begin
          skid_q <= in_data;
          state <= SKID;
        end else if (out_ready) state <= EMPTY;
        SKID: if (out_ready) begin
          main_q <= skid_q;
          state <= FULL;
        end
        default: state <= EMPTY;
      endcase
endmodule

// File: rtl/decode_execute_pipe.sv
// decode_execute_pipe: decode->execute stage register with backpressure, flush and stall counter
module decode_execute_pipe import de_pipe_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_W = 4,
  parameter int CMD_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  dest_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              wb_en_in,
  input  logic              br_taken_in,
  input  logic [CMD_W-1:0]  exe_cmd_in,
  input  logic [REG_W-1:0]  src1_in,
  input  logic [REG_W-1:0]  src2_in,
  input  logic [DATA_W-1:0] val1_in,
  input  logic [DATA_W-1:0] val2_in,
  input  logic [DATA_W-1:0] st_val_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_W-1:0]  dest_out,
  output logic [CMD_W-1:0]  exe_cmd_out,
  output logic [REG_W-1:0]  src1_out,
  output logic [REG_W-1:0]  src2_out,
  output logic [DATA_W-1:0] val1_out,
  output logic [DATA_W-1:0] val2_out,
  output logic [DATA_W-1:0] st_val_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              wb_en_out,
  output logic              br_taken_out,
  output logic [CNT_W-1:0]  stall_cycles
);
  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic [CMD_W-1:0] exe_cmd;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] st_val;
    de_ctrl_t ctrl;
  } pay_t;
  localparam int PW = $bits(pay_t);
  localparam logic [PW-1:0] KEEP = {{(PW-CTRL_W){1'b1}}, {CTRL_W{1'b0}}};
  pay_t d, q;
  de_ctrl_t ctrl;
  assign d = {dest_in, exe_cmd_in, src1_in, src2_in, val1_in, val2_in, st_val_in,
              mem_r_en_in, mem_w_en_in, wb_en_in, br_taken_in};
  pipe_skid_buffer #(.W(PW), .KEEP_MASK(KEEP)) u_skid (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(q)
  );
  assign ctrl = ctrl_keep(q.ctrl, out_valid);
  assign {mem_r_en_out, mem_w_en_out, wb_en_out, br_taken_out} = ctrl;
  assign dest_out = q.dest;
  assign exe_cmd_out = q.exe_cmd;
  assign src1_out = q.src1;
  assign src2_out = q.src2;
  assign val1_out = q.val1;
  assign val2_out = q.val2;
  assign st_val_out = q.st_val;
  // saturating count of cycles where Execute holds off a valid bundle
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cycles <= '0;
    else if (out_valid && !out_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
endmodule

// File: tb/tb_decode_execute_pipe.sv
// tb_decode_execute_pipe: table-driven and scoreboard checks of decode_execute_pipe
module tb_decode_execute_pipe;
  localparam int DW = 64, RW = 5, CW = 4, SW = 4;
  localparam int SMAX = (1 << SW) - 1;
  typedef struct packed {
    logic [RW-1:0] dest;
    logic [CW-1:0] cmd;
    logic [RW-1:0] src1;
    logic [RW-1:0] src2;
    logic [DW-1:0] v1;
    logic [DW-1:0] v2;
    logic [DW-1:0] st;
    logic [3:0] ctrl;
  } bun_t;
  typedef struct {
    logic vld, ordy, fl, eir, eov;
    logic [RW-1:0] dest, s2;
    logic [DW-1:0] v1, v2;
    logic [3:0] ctrl;
  } vec_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  bun_t cur = '0;
  logic in_ready, out_valid, mem_r_en_out, mem_w_en_out, wb_en_out, br_taken_out;
  logic [RW-1:0] dest_out, src1_out, src2_out;
  logic [CW-1:0] exe_cmd_out;
  logic [DW-1:0] val1_out, val2_out, st_val_out;
  logic [SW-1:0] stall_cycles;
  bun_t q[$];
  int errors = 0, checks = 0, exp_stall = 0;
  vec_t tv[17];

  decode_execute_pipe #(.DATA_W(DW), .REG_W(RW), .CMD_W(CW), .CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .dest_in(cur.dest), .mem_r_en_in(cur.ctrl[3]), .mem_w_en_in(cur.ctrl[2]),
    .wb_en_in(cur.ctrl[1]), .br_taken_in(cur.ctrl[0]), .exe_cmd_in(cur.cmd),
    .src1_in(cur.src1), .src2_in(cur.src2), .val1_in(cur.v1), .val2_in(cur.v2),
    .st_val_in(cur.st), .out_valid(out_valid), .out_ready(out_ready),
    .dest_out(dest_out), .exe_cmd_out(exe_cmd_out), .src1_out(src1_out),
    .src2_out(src2_out), .val1_out(val1_out), .val2_out(val2_out),
    .st_val_out(st_val_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .wb_en_out(wb_en_out), .br_taken_out(br_taken_out), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic bun_t seen();
    return {dest_out, exe_cmd_out, src1_out, src2_out, val1_out, val2_out, st_val_out,
            mem_r_en_out, mem_w_en_out, wb_en_out, br_taken_out};
  endfunction

  function automatic vec_t mkv(logic vld, logic ordy, logic fl, logic eir, logic eov,
                               logic [RW-1:0] dest, logic [RW-1:0] s2,
                               logic [DW-1:0] v1, logic [DW-1:0] v2, logic [3:0] ctrl);
    return '{vld: vld, ordy: ordy, fl: fl, eir: eir, eov: eov, dest: dest, s2: s2,
             v1: v1, v2: v2, ctrl: ctrl};
  endfunction

  // called just after a falling edge with inputs already set; ends on the next falling edge
  task automatic tick();
    int n;
    #1;
    n = q.size();
    chk("out_valid", out_valid, n != 0);
    chk("in_ready", in_ready, n < 2);
    chk("stall_cycles", stall_cycles, exp_stall);
    if (n != 0) chk("payload", seen(), q[0]);
    else chk("bubble_ctrl", {mem_r_en_out, mem_w_en_out, wb_en_out, br_taken_out}, 0);
    if (n != 0 && out_ready) void'(q.pop_front());
    if (n != 0 && !out_ready && exp_stall < SMAX) exp_stall++;
    if (flush) q.delete();
    else if (in_valid && n < 2) q.push_back(cur);
    @(negedge clk);
  endtask

  initial begin
    tv[0]  = mkv(1, 1, 0, 1, 0, 1, 31, 64'h11, 64'hDEAD_BEEF_0123_4567, 4'b0010);
    tv[1]  = mkv(1, 1, 0, 1, 1, 2, 5, 64'h22, 64'h2222, 4'b1000);
    tv[2]  = mkv(1, 1, 0, 1, 1, 3, 7, 64'h33, 64'h3333, 4'b0100);
    tv[3]  = mkv(0, 1, 0, 1, 1, 0, 0, 0, 0, 4'b0000);
    tv[4]  = mkv(1, 0, 0, 1, 0, 4, 1, 64'hAAAA_0001, 64'h4, 4'b0011);
    tv[5]  = mkv(1, 0, 0, 1, 1, 5, 2, 64'hBBBB_0002, 64'h5, 4'b0110);
    tv[6]  = mkv(1, 0, 0, 0, 1, 6, 3, 64'hCCCC_0003, 64'h6, 4'b1111);
    tv[7]  = mkv(0, 1, 0, 0, 1, 0, 0, 0, 0, 4'b0000);
    tv[8]  = mkv(0, 1, 0, 1, 1, 0, 0, 0, 0, 4'b0000);
    tv[9]  = mkv(0, 1, 0, 1, 0, 0, 0, 0, 0, 4'b0000);
    tv[10] = mkv(1, 0, 0, 1, 0, 7, 4, 64'h7777, 64'h7, 4'b0010);
    tv[11] = mkv(1, 0, 0, 1, 1, 8, 6, 64'h8888, 64'h8, 4'b0010);
    tv[12] = mkv(1, 0, 1, 0, 1, 9, 9, 64'h9999, 64'h9, 4'b0010);
    tv[13] = mkv(0, 1, 0, 1, 0, 0, 0, 0, 0, 4'b0000);
    tv[14] = mkv(1, 0, 0, 1, 0, 10, 10, 64'hA0A0, 64'hA, 4'b1110);
    tv[15] = mkv(1, 0, 1, 1, 1, 11, 11, 64'hB0B0, 64'hB, 4'b0010);
    tv[16] = mkv(0, 1, 0, 1, 0, 0, 0, 0, 0, 4'b0000);
    #1 rst = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_payload", seen(), 0);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 17; i++) begin
      cur = '{dest: tv[i].dest, cmd: CW'($urandom()), src1: RW'($urandom()), src2: tv[i].s2,
              v1: tv[i].v1, v2: tv[i].v2, st: {$urandom(), $urandom()}, ctrl: tv[i].ctrl};
      in_valid = tv[i].vld;
      out_ready = tv[i].ordy;
      flush = tv[i].fl;
      #1;
      chk($sformatf("row%0d_in_ready", i), in_ready, tv[i].eir);
      chk($sformatf("row%0d_out_valid", i), out_valid, tv[i].eov);
      tick();
    end
    flush = 0;
    cur = '{dest: 12, cmd: 3, src1: 1, src2: 2, v1: 64'h1212, v2: 64'h3434, st: 64'h5656, ctrl: 4'b0100};
    in_valid = 1;
    out_ready = 0;
    tick();
    in_valid = 0;
    repeat (20) tick();
    chk("stall_saturated", stall_cycles, SMAX);
    out_ready = 1;
    tick();
    tick();
    cur = '{dest: 13, cmd: 5, src1: 3, src2: 4, v1: 64'h1313, v2: 64'h1414, st: 64'h1515, ctrl: 4'b1111};
    in_valid = 1;
    out_ready = 0;
    tick();
    in_valid = 0;
    tick();
    #2 rst = 0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_ctrl", {mem_r_en_out, mem_w_en_out, wb_en_out, br_taken_out}, 0);
    chk("async_stall", stall_cycles, 0);
    chk("async_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("held_in_ready", in_ready, 0);
    chk("held_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1;
    q.delete();
    exp_stall = 0;
    out_ready = 1;
    tick();
    cur = '{dest: 14, cmd: 6, src1: 5, src2: 31, v1: 64'h1, v2: 64'hDEAD_BEEF_0123_4567, st: 64'h2, ctrl: 4'b1001};
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    chk("drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
